// File: rtl/bootram_bus_ctrl_if.sv
// rtl/bootram_bus_ctrl_if.sv - PicoRV32 native memory-bus bundle for the boot RAM requester
interface bootram_bus_ctrl_if;
    logic        sel;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // CPU / decoder side drives the request and consumes the response
    modport master (
        output sel,
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    // Boot RAM controller side
    modport slave (
        input  sel,
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/bootram_bus_ctrl.sv
// rtl/bootram_bus_ctrl.sv - boot RAM bus requester for four byte-lane SP RAMs; optional write protect via BOOTRAM_WP_EN
module bootram_bus_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                reset,
    bootram_bus_ctrl_if.slave   bus,
    output logic                ram_ce,
    output logic                ram_oce,
    output logic                ram_reset,
    output logic [3:0]          ram_wre,
    output logic [ADDR_W-1:0]   ram_ad,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout,
    output logic                wp_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_RDCAP = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_is_write;
    logic        w_ram_ce;
    logic [3:0]  w_ram_wre;
    logic        r_mem_ready;
    logic [31:0] r_mem_rdata;

    // Byte-offset and above-window address bits play no part in the lookup;
    // the window wraps modulo the RAM size.
    logic        w_unused_addr;
    assign w_unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

    assign w_is_write = (bus.mem_wstrb != 4'b0000);

    // State register; reset discards any in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and single-cycle RAM strobes; strobes fire only on acceptance
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_ram_ce  = 1'b0;
        w_ram_wre = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_valid && bus.sel) begin
                    w_accept = 1'b1;
                    w_ram_ce = 1'b1;
                    if (w_is_write) begin
`ifdef BOOTRAM_WP_EN
                        w_ram_wre = 4'b0000;
`else
                        w_ram_wre = bus.mem_wstrb;
`endif
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD:    w_next = ST_RDCAP;
            ST_RDCAP: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Ready is registered: high for exactly the cycle spent in RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_ready <= 1'b0;
        end else begin
            r_mem_ready <= (w_next == ST_RESP);
        end
    end

    // RAM output has settled by RDCAP; capture it and hold until the next read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_rdata <= 32'h0000_0000;
        end else if (r_state == ST_RDCAP) begin
            r_mem_rdata <= ram_dout;
        end
    end

`ifdef BOOTRAM_WP_EN
    logic r_wp_err;

    // Sticky flag: any write that was acknowledged but not performed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp_err <= 1'b0;
        end else if (w_accept && w_is_write) begin
            r_wp_err <= 1'b1;
        end
    end

    assign wp_err = r_wp_err;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign wp_err          = 1'b0;
`endif

    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_rdata = r_mem_rdata;

    assign ram_ce    = w_ram_ce;
    assign ram_wre   = w_ram_wre;
    assign ram_ad    = bus.mem_addr[ADDR_W+1:2];
    assign ram_din   = bus.mem_wdata;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// tb/tb_bootram_bus_ctrl.sv - directed self-checking bench for bootram_bus_ctrl with a byte-lane RAM model
module tb_bootram_bus_ctrl;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              ram_ce;
    logic              ram_oce;
    logic              ram_reset;
    logic [3:0]        ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic              wp_err;

    int checks = 0;
    int errors = 0;

    bootram_bus_ctrl_if bus ();

    bootram_bus_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .wp_err    (wp_err)
    );

    always #5 clk = ~clk;

    // Four 2048x8 lanes, bypass read mode, one-cycle read latency, plus backdoor load
    logic [7:0]        lane_mem [4][2048];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_ad = '0;
    logic [31:0]       bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) begin
            for (int i = 0; i < 4; i++) lane_mem[i][bd_ad] <= bd_data[8*i +: 8];
        end
        if (ram_reset) begin
            ram_dout <= 32'h0;
        end else if (ram_ce) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_wre[i]) lane_mem[i][ram_ad] <= ram_din[8*i +: 8];
                else            ram_dout[8*i +: 8] <= lane_mem[i][ram_ad];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [31:0] exp_ad, input logic [3:0] exp_wre);
        @(negedge clk);
        bus.sel = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
        #1;
        chk("wr_ce", {31'd0, ram_ce}, 32'd1);
        chk("wr_wre", {28'd0, ram_wre}, {28'd0, exp_wre});
        chk("wr_ad", {21'd0, ram_ad}, exp_ad);
        chk("wr_din", ram_din, d);
        chk("wr_ready_c0", {31'd0, bus.mem_ready}, 32'd0);
        @(negedge clk);
        chk("wr_ready_c1", {31'd0, bus.mem_ready}, 32'd1);
        chk("wr_ce_c1", {31'd0, ram_ce}, 32'd0);
        chk("wr_wre_c1", {28'd0, ram_wre}, 32'd0);
        bus.sel = 1'b0; bus.mem_valid = 1'b0; bus.mem_wstrb = 4'h0;
        @(negedge clk);
        chk("wr_ready_c2", {31'd0, bus.mem_ready}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_ad, input logic [31:0] exp_d);
        @(negedge clk);
        bus.sel = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wstrb = 4'h0;
        #1;
        chk("rd_ce", {31'd0, ram_ce}, 32'd1);
        chk("rd_wre", {28'd0, ram_wre}, 32'd0);
        chk("rd_ad", {21'd0, ram_ad}, exp_ad);
        @(negedge clk);
        // Dropping the request after acceptance must not abort the read
        bus.sel = 1'b0; bus.mem_valid = 1'b0;
        chk("rd_ready_c1", {31'd0, bus.mem_ready}, 32'd0);
        chk("rd_ce_c1", {31'd0, ram_ce}, 32'd0);
        @(negedge clk);
        chk("rd_ready_c2", {31'd0, bus.mem_ready}, 32'd0);
        @(negedge clk);
        chk("rd_ready_c3", {31'd0, bus.mem_ready}, 32'd1);
        chk("rd_data_c3", bus.mem_rdata, exp_d);
        @(negedge clk);
        chk("rd_ready_c4", {31'd0, bus.mem_ready}, 32'd0);
        chk("rd_hold_c4", bus.mem_rdata, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.sel = 1'b0; bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        #12;
        chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_wp_err", {31'd0, wp_err}, 32'd0);
        chk("rst_ce", {31'd0, ram_ce}, 32'd0);
        chk("rst_wre", {28'd0, ram_wre}, 32'd0);
        chk("rst_oce", {31'd0, ram_oce}, 32'd1);
        chk("rst_ram_reset", {31'd0, ram_reset}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ram_reset_low", {31'd0, ram_reset}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, bus.mem_ready}, 32'd0);
            chk("idle_ce", {31'd0, ram_ce}, 32'd0);
            chk("idle_wre", {28'd0, ram_wre}, 32'd0);
            chk("idle_rdata", bus.mem_rdata, 32'd0);
        end

`ifdef BOOTRAM_WP_EN
        @(negedge clk);
        bd_we = 1'b1; bd_ad = 11'd8; bd_data = 32'hCAFE_F00D;
        @(negedge clk);
        bd_we = 1'b0;
        do_write(32'h0000_0020, 32'h0000_0055, 4'hF, 32'd8, 4'h0);
        chk("wp_err_set", {31'd0, wp_err}, 32'd1);
        do_read(32'h0000_0020, 32'd8, 32'hCAFE_F00D);
        chk("wp_err_sticky", {31'd0, wp_err}, 32'd1);
`else
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd4, 4'hF);
        do_read(32'h0000_0010, 32'd4, 32'hDEAD_BEEF);

        do_write(32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'd4, 4'b0001);
        do_read(32'h0000_0010, 32'd4, 32'hDEAD_BEAA);

        // Unrelated write leaves the last read value on mem_rdata
        do_write(32'h0000_0040, 32'h1122_3344, 4'hF, 32'd16, 4'hF);
        chk("rdata_hold_wr", bus.mem_rdata, 32'hDEAD_BEAA);

        do_write(32'h0000_2000, 32'h1234_5678, 4'hF, 32'd0, 4'hF);
        do_read(32'h0000_0000, 32'd0, 32'h1234_5678);
        // High address bits and byte offset ignored: 0xFFFFE013 -> word 4
        do_read(32'hFFFF_E013, 32'd4, 32'hDEAD_BEAA);
        chk("wp_err_off", {31'd0, wp_err}, 32'd0);
`endif

        // Request without decoder hit is ignored
        @(negedge clk);
        bus.sel = 1'b0; bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_0010; bus.mem_wstrb = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("nosel_ce", {31'd0, ram_ce}, 32'd0);
            chk("nosel_wre", {28'd0, ram_wre}, 32'd0);
            @(negedge clk);
            chk("nosel_ready", {31'd0, bus.mem_ready}, 32'd0);
        end
        bus.mem_valid = 1'b0; bus.mem_wstrb = 4'h0;

        // Reset while in RD discards the read
        @(negedge clk);
        bus.sel = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_0010; bus.mem_wstrb = 4'h0;
        #1;
        chk("rstrd_ce", {31'd0, ram_ce}, 32'd1);
        @(negedge clk);
        bus.sel = 1'b0; bus.mem_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstrd_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rstrd_rdata", bus.mem_rdata, 32'd0);
        chk("rstrd_wp_err", {31'd0, wp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstrd_noready", {31'd0, bus.mem_ready}, 32'd0);
            chk("rstrd_ce_idle", {31'd0, ram_ce}, 32'd0);
        end
`ifdef BOOTRAM_WP_EN
        do_read(32'h0000_0020, 32'd8, 32'hCAFE_F00D);
`else
        do_read(32'h0000_0000, 32'd0, 32'h1234_5678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
